// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory read port, redirect input, decode handshake
// and occupancy/perf observation. master = fetch stage, slave = its environment.
interface if_fetch_queue_if #(
  parameter int QUEUE_DEPTH = 4
) ();
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          fetch_en;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr;
  logic [31:0]   dec_pc;
  logic [CW-1:0] q_count;
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;

  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_pc, dec_ready,
    output imem_addr, dec_valid, dec_instr, dec_pc, q_count,
           perf_fetch_cnt, perf_stall_cnt
  );

  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_pc, dec_ready,
    input  imem_addr, dec_valid, dec_instr, dec_pc, q_count,
           perf_fetch_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC, captures {pc, instr} into a prefetch queue and
// feeds decode. Optional perf counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] PC_STEP     = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_queue_if.master bus
);
  localparam int            PW       = $clog2(QUEUE_DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic                         dec_valid_q, dec_valid_d;
  logic [31:0]                  pc_q, pc_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [QUEUE_DEPTH-1:0][31:0] pc_mem_q, pc_mem_d;
  logic [QUEUE_DEPTH-1:0][31:0] ins_mem_q, ins_mem_d;
  logic                         full, pop, push;

  // A redirect voids any handshake in the same cycle, so it gates both pop and push.
  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = dec_valid_q & bus.dec_ready & ~bus.redirect_valid;
    push = bus.fetch_en & (~full | pop) & ~bus.redirect_valid;
  end

  always_comb begin
    state_d   = ST_RUN;
    pc_d      = pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pc_mem_d  = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (bus.redirect_valid) begin
      state_d  = ST_FLUSH;
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]  = pc_q;
        ins_mem_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d            = wr_ptr_q + 1'b1;
        pc_d                = pc_q + PC_STEP;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    dec_valid_d = (state_d == ST_RUN) && (count_d != '0);
  end

  // Control FSM: FLUSH lasts exactly the cycle after a redirect and holds dec_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pc_mem_q  <= '0;
      ins_mem_q <= '0;
    end else begin
      pc_q      <= pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pc_mem_q  <= pc_mem_d;
      ins_mem_q <= ins_mem_d;
    end
  end

  // Head is read from storage flops only; imem_rdata never reaches decode directly.
  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_instr = ins_mem_q[rd_ptr_q];
  assign bus.dec_pc    = pc_mem_q[rd_ptr_q];
  assign bus.q_count   = count_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  always_comb begin
    stall        = bus.fetch_en & full & ~pop;
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (push  && (perf_fetch_q != '1)) perf_fetch_d = perf_fetch_q + 32'd1;
    if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_q;
  assign bus.perf_stall_cnt = perf_stall_q;
`else
  assign bus.perf_fetch_cnt = 32'd0;
  assign bus.perf_stall_cnt = 32'd0;
`endif
endmodule
